// File: rtl/div_iter.sv
// ---------------------------------------------------------------------------
// div_iter
//   Iterative radix-2 restoring divider for DIV/DIVU in the execute stage.
//   It accepts one divide and produces one quotient bit per cycle, MSB first.
//   While the divide is in flight it holds F/D/E by driving stall_div into the
//   hazard unit. An annul (flushE) aborts the divide at any point. When the
//   divide completes, the divider presents {remainder, quotient} for the HI/LO
//   write path.
//
// Ports
//   clk         in   1        rising-edge clock
//   rst         in   1        synchronous, active-high reset
//   start       in   1        divide op present in E stage
//   signed_div  in   1        1 = DIV (two's complement), 0 = DIVU
//   opa         in   WIDTH    dividend, sampled only at accept
//   opb         in   WIDTH    divisor, sampled only at accept
//   annul       in   1        abort request (flushE)
//   stall_div   out  1        pipeline stall request, combinational
//   ready       out  1        result valid this cycle (DONE state)
//   result      out  2*WIDTH  {remainder, quotient}, held until next DONE
// ---------------------------------------------------------------------------
module div_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opa,
    input  logic [WIDTH-1:0]   opb,
    input  logic               annul,
    output logic               stall_div,
    output logic               ready,
    output logic [2*WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0] counter;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic             sign_q;
    logic             sign_r;

    logic             opb_zero;
    logic             last_iter;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             q_bit;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

    assign opb_zero  = (opb == '0);
    assign last_iter = (counter == CNT_W'(WIDTH - 1));

    // Operand magnitudes; for DIVU the raw bit patterns are used directly.
    // The most negative value maps onto itself, which is the correct unsigned
    // magnitude, so min_int / -1 needs no special handling.
    assign mag_a = (signed_div && opa[WIDTH-1]) ? -opa : opa;
    assign mag_b = (signed_div && opb[WIDTH-1]) ? -opb : opb;

    // One restoring step. The dividend shifts out of quo MSB-first while the
    // quotient bits shift in at the bottom, so quo holds both halves in flight.
    // The partial remainder always stays below the divisor, so WIDTH+1 bits
    // are enough for the trial subtraction and its borrow.
    assign shifted  = {rem, quo[WIDTH-1]};
    assign diff     = shifted - {1'b0, divisor};
    assign q_bit    = ~diff[WIDTH];
    assign rem_step = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_step = {quo[WIDTH-2:0], q_bit};

    // Sign fix-ups applied to the final step's outputs, with natural wrap.
    assign q_final = sign_q ? -quo_step : quo_step;
    assign r_final = sign_r ? -rem_step : rem_step;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs. DONE always returns to IDLE so the
    // instruction that is still presenting start in DONE cannot restart.
    // An annul overrides everything: the pipeline is not stalled that cycle
    // and no result is reported.
    always_comb begin
        state_next = state;
        stall_div  = 1'b0;
        ready      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    stall_div  = 1'b1;
                    state_next = opb_zero ? DONE : BUSY;
                end
            end
            BUSY: begin
                stall_div = 1'b1;
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                ready      = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (annul) begin
            state_next = IDLE;
            stall_div  = 1'b0;
            ready      = 1'b0;
        end
    end

    // Datapath. Operands are captured only at accept. The result register is
    // written only on the edge that enters DONE and holds until the next one.
    // A divide by zero bypasses the iterations and reports all-ones quotient
    // with the raw dividend as remainder.
    always_ff @(posedge clk) begin
        if (rst) begin
            counter <= '0;
            divisor <= '0;
            quo     <= '0;
            rem     <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            result  <= '0;
        end else if (!annul) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        divisor <= mag_b;
                        quo     <= mag_a;
                        rem     <= '0;
                        counter <= '0;
                        sign_q  <= signed_div & (opa[WIDTH-1] ^ opb[WIDTH-1]);
                        sign_r  <= signed_div & opa[WIDTH-1];
                        if (opb_zero) begin
                            result <= {opa, {WIDTH{1'b1}}};
                        end
                    end
                end
                BUSY: begin
                    rem     <= rem_step;
                    quo     <= quo_step;
                    counter <= counter + 1'b1;
                    if (last_iter) begin
                        result <= {r_final, q_final};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// ---------------------------------------------------------------------------
// tb_div_iter
//   Self-checking bench for div_iter (WIDTH=32). Directed vectors from a table,
//   hand-written annul/reset/back-to-back sequences, and random divides
//   checked against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        annul;
    logic        stall_div;
    logic        ready;
    logic [63:0] result;

    int tests    = 0;
    int failures = 0;

    typedef struct {
        bit          sd;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] expected;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    div_iter #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .opa        (opa),
        .opb        (opb),
        .annul      (annul),
        .stall_div  (stall_div),
        .ready      (ready),
        .result     (result)
    );

    // Reference: plain 64-bit arithmetic (truncating division, remainder takes
    // the dividend's sign), with the divide-by-zero convention layered on top.
    function automatic logic [63:0] refDiv(input bit sd, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        if (sd) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
        end else begin
            sa = {32'h0, a};
            sb = {32'h0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Runs one divide from accept to DONE and checks stall count, the result
    // and that stall is released in the DONE cycle. Returns at the DONE cycle
    // with start still high; operands are scrambled after accept.
    task automatic applyStimulus(input bit sd, input logic [31:0] a, input logic [31:0] b,
                                 input logic [63:0] expected, input string name);
        int stalls = 0;
        bit got = 1'b0;
        @(negedge clk);
        start      = 1'b1;
        signed_div = sd;
        opa        = a;
        opb        = b;
        annul      = 1'b0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (ready) begin
                got = 1'b1;
                break;
            end
            if (stall_div) stalls++;
            @(negedge clk);
            opa = $urandom;
            opb = $urandom;
        end
        checkOutput({name, " ready"}, 64'(got), 64'd1);
        checkOutput({name, " result"}, result, expected);
        checkOutput({name, " stalls"}, 64'(stalls), (b == 32'h0) ? 64'd1 : 64'd33);
        checkOutput({name, " stall in done"}, 64'(stall_div), 64'd0);
    endtask

    // Cycle after DONE with start dropped: must be quiet IDLE, not a restart.
    task automatic checkIdle(input string name);
        @(negedge clk);
        start = 1'b0;
        #1;
        checkOutput({name, " idle after done"}, {62'h0, stall_div, ready}, 64'h0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] prior;
        logic [31:0] ra;
        logic [31:0] rb;
        bit          rsd;
        int          sel;

        vecs[0] = '{1'b0, 32'd7,        32'd2,        {32'h1,        32'h3}};
        vecs[1] = '{1'b1, 32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}};
        vecs[2] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0,        32'h80000000}};
        vecs[3] = '{1'b0, 32'd5,        32'd0,        {32'h5,        32'hFFFFFFFF}};
        vecs[4] = '{1'b1, 32'd7,        32'hFFFFFFFE, {32'h1,        32'hFFFFFFFD}};
        vecs[5] = '{1'b0, 32'hFFFFFFFF, 32'd1,        {32'h0,        32'hFFFFFFFF}};
        vecs[6] = '{1'b1, 32'hFFFFFFFB, 32'd0,        {32'hFFFFFFFB, 32'hFFFFFFFF}};
        vecs[7] = '{1'b0, 32'd1,        32'hFFFFFFFF, {32'h1,        32'h0}};

        rst        = 1'b1;
        start      = 1'b0;
        signed_div = 1'b0;
        opa        = 32'h0;
        opb        = 32'h0;
        annul      = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset ready", 64'(ready), 64'd0);
        checkOutput("reset stall", 64'(stall_div), 64'd0);
        checkOutput("reset result", result, 64'h0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].sd, vecs[i].a, vecs[i].b, vecs[i].expected, $sformatf("vec%0d", i));
            checkIdle($sformatf("vec%0d", i));
        end

        // Annul during BUSY iteration 10.
        prior = result;
        @(negedge clk);
        start      = 1'b1;
        signed_div = 1'b0;
        opa        = 32'd1000;
        opb        = 32'd3;
        repeat (11) @(negedge clk);
        annul = 1'b1;
        #1;
        checkOutput("annul stall", 64'(stall_div), 64'd0);
        checkOutput("annul ready", 64'(ready), 64'd0);
        @(negedge clk);
        annul = 1'b0;
        start = 1'b0;
        #1;
        checkOutput("annul idle", {62'h0, stall_div, ready}, 64'h0);
        checkOutput("annul result kept", result, prior);

        // Back-to-back after annul: full stalls each, start held through DONE.
        applyStimulus(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, "b2b first");
        applyStimulus(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, "b2b second");
        checkIdle("b2b second");

        // Reset during BUSY iteration 20.
        @(negedge clk);
        start      = 1'b1;
        signed_div = 1'b1;
        opa        = 32'd12345;
        opb        = 32'd7;
        repeat (21) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        #1;
        checkOutput("rst idle", {62'h0, stall_div, ready}, 64'h0);
        checkOutput("rst result", result, 64'h0);

        // Random divides against the reference model.
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            rsd = 1'($urandom_range(0, 1));
            ra  = $urandom;
            if (sel == 0)      rb = 32'h0;
            else if (sel < 4)  rb = 32'($urandom_range(1, 15));
            else if (sel == 4) rb = 32'hFFFFFFFF;
            else               rb = $urandom;
            if (sel == 4 && i % 2 == 0) ra = 32'h80000000;
            applyStimulus(rsd, ra, rb, refDiv(rsd, ra, rb), $sformatf("rand%0d", i));
            if (i % 3 != 0) checkIdle($sformatf("rand%0d", i));
        end
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
